seq_mult: RTL and testbench

Iterative shift-add 32×32 multiplier that serves the execute stage's multiply request. The execute stage pulses `start` with `is_signed` and its operands, and the hazard unit stalls on `busy`. The block returns a 64-bit product on `hi`/`lo`, which the output mux reads as the MFHI/MFLO sources. One operation is in flight at a time; the result registers hold until the next operation completes.

---
 rtl/seq_mult_pkg.sv | 18 +
 rtl/seq_mult.sv | 127 ++++++++++++
 tb/tb_seq_mult.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the iterative shift-add multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  localparam int SEQ_MULT_WIDTH = 32;
  localparam int SEQ_MULT_CNT_W = $clog2(SEQ_MULT_WIDTH);

  // Step counter width for an arbitrary operand width (power of two).
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/seq_mult.sv
// Iterative shift-add WIDTHxWIDTH multiplier: busy for WIDTH+1 cycles (data-dependent when
// SEQ_MULT_EARLY_OUT_EN is defined); start is ignored while busy, hi/lo hold until the next FIX edge.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = SEQ_MULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [WIDTH-1:0]     mplier_shift;
  logic [2*WIDTH-1:0]   acc_sum;
  logic [2*WIDTH-1:0]   acc_neg;
  logic                 run_last;

  // |-2^(WIDTH-1)| wraps to itself, which is the correct unsigned magnitude.
  assign mag_a        = (is_signed && a[WIDTH-1]) ? -a : a;
  assign mag_b        = (is_signed && b[WIDTH-1]) ? -b : b;
  assign mplier_shift = mplier_q >> 1;
  assign acc_sum      = acc_q + mcand_q;
  assign acc_neg      = -acc_q;

`ifdef SEQ_MULT_EARLY_OUT_EN
  assign run_last = (cnt_q == CNT_LAST) || (mplier_shift == '0);
`else
  assign run_last = (cnt_q == CNT_LAST);
`endif

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, mag_a};
          mplier_d = mag_b;
          neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (mplier_q[0]) begin
          acc_d = acc_sum;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_shift;
        cnt_d    = cnt_q + CNT_ONE;
        if (run_last) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        {hi_d, lo_d} = neg_q ? acc_neg : acc_q;
        done_d       = 1'b1;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_seq_mult.sv
// Directed self-checking bench for seq_mult at WIDTH=32.
module tb_seq_mult;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

`ifdef SEQ_MULT_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  always #5 clk = ~clk;

  seq_mult #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  // Issues one operation and follows it to the first non-busy cycle; optionally pulses a
  // second start at busy cycle inj_cyc. Entered and left 1 time unit after a rising edge.
  task automatic run_op(input logic [31:0] aa, input logic [31:0] bb, input logic sg,
                        input int inj_cyc, input logic [31:0] ia, input logic [31:0] ib,
                        output int nbusy, output int hold_err, output int done_busy,
                        output logic done_end, output logic [31:0] rhi, output logic [31:0] rlo);
    logic [31:0] ohi;
    logic [31:0] olo;
    ohi = hi;
    olo = lo;
    a = aa;
    b = bb;
    is_signed = sg;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nbusy = 0;
    hold_err = 0;
    done_busy = 0;
    while (busy === 1'b1 && nbusy < 200) begin
      nbusy++;
      if (hi !== ohi || lo !== olo) hold_err++;
      if (done !== 1'b0) done_busy++;
      if (nbusy == inj_cyc) begin
        a = ia;
        b = ib;
        start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    done_end = done;
    rhi = hi;
    rlo = lo;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    is_signed = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
  endtask

  task automatic test_unsigned_max();
    int nb, he, db;
    logic de;
    logic [31:0] rh, rl;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 32'h0, 32'h0, nb, he, db, de, rh, rl);
    checks++; if (nb !== 33) begin errors++; $display("FAIL umax_busy_cycles: got %0d expected 33", nb); end
    checks++; if (he !== 0) begin errors++; $display("FAIL umax_hold: got %0d changes expected 0", he); end
    checks++; if (db !== 0) begin errors++; $display("FAIL umax_done_early: got %0d expected 0", db); end
    checks++; if (de !== 1'b1) begin errors++; $display("FAIL umax_done: got %b expected 1", de); end
    checks++; if (rh !== 32'hFFFF_FFFE) begin errors++; $display("FAIL umax_hi: got %h expected fffffffe", rh); end
    checks++; if (rl !== 32'h0000_0001) begin errors++; $display("FAIL umax_lo: got %h expected 00000001", rl); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL umax_done_width: got %b expected 0", done); end
    checks++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h1) begin errors++; $display("FAIL umax_result_hold: got %h_%h expected fffffffe_00000001", hi, lo); end
  endtask

  task automatic test_signed();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic        vs [4];
    logic [31:0] eh [4];
    logic [31:0] el [4];
    int nb, he, db;
    logic de;
    logic [31:0] rh, rl;
    va[0] = 32'hFFFF_FFFD; vb[0] = 32'h7; vs[0] = 1'b1; eh[0] = 32'hFFFF_FFFF; el[0] = 32'hFFFF_FFEB;
    va[1] = 32'hFFFF_FFFD; vb[1] = 32'h7; vs[1] = 1'b0; eh[1] = 32'h0000_0006; el[1] = 32'hFFFF_FFEB;
    va[2] = 32'h8000_0000; vb[2] = 32'h8000_0000; vs[2] = 1'b1; eh[2] = 32'h4000_0000; el[2] = 32'h0;
    va[3] = 32'h8000_0000; vb[3] = 32'h1; vs[3] = 1'b1; eh[3] = 32'hFFFF_FFFF; el[3] = 32'h8000_0000;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], vs[i], 0, 32'h0, 32'h0, nb, he, db, de, rh, rl);
      checks++; if (de !== 1'b1) begin errors++; $display("FAIL signed_done[%0d]: got %b expected 1", i, de); end
      checks++; if (rh !== eh[i]) begin errors++; $display("FAIL signed_hi[%0d]: got %h expected %h", i, rh, eh[i]); end
      checks++; if (rl !== el[i]) begin errors++; $display("FAIL signed_lo[%0d]: got %h expected %h", i, rl, el[i]); end
    end
  endtask

  task automatic test_start_ignored();
    int nb, he, db, busy_seen;
    logic de;
    logic [31:0] rh, rl;
    int exp_nb;
    exp_nb = EARLY ? 4 : 33;
    run_op(32'd2, 32'd3, 1'b0, 0, 32'h0, 32'h0, nb, he, db, de, rh, rl);
    checks++; if (rh !== 32'd0 || rl !== 32'd6) begin errors++; $display("FAIL ign_first: got %h_%h expected 00000000_00000006", rh, rl); end
    run_op(32'd5, 32'd5, 1'b0, 5, 32'd9, 32'd9, nb, he, db, de, rh, rl);
    checks++; if (he !== 0) begin errors++; $display("FAIL ign_hold: got %0d changes expected 0", he); end
    checks++; if (nb !== exp_nb) begin errors++; $display("FAIL ign_busy_cycles: got %0d expected %0d", nb, exp_nb); end
    checks++; if (rh !== 32'd0 || rl !== 32'd25) begin errors++; $display("FAIL ign_result: got %h_%h expected 00000000_00000019", rh, rl); end
    busy_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (busy !== 1'b0) busy_seen++;
    end
    checks++; if (busy_seen !== 0) begin errors++; $display("FAIL ign_second_op: got %0d busy cycles expected 0", busy_seen); end
    checks++; if (lo !== 32'd25) begin errors++; $display("FAIL ign_final_lo: got %h expected 00000019", lo); end
  endtask

  task automatic test_back_to_back();
    int nb, he, db;
    logic de;
    logic [31:0] rh, rl;
    int exp_nb;
    exp_nb = EARLY ? 5 : 33;
    run_op(32'd6, 32'd7, 1'b0, 0, 32'h0, 32'h0, nb, he, db, de, rh, rl);
    checks++; if (de !== 1'b1 || rl !== 32'd42) begin errors++; $display("FAIL b2b_first: got done=%b lo=%h expected done=1 lo=0000002a", de, rl); end
    run_op(32'd11, 32'd13, 1'b0, 0, 32'h0, 32'h0, nb, he, db, de, rh, rl);
    checks++; if (nb !== exp_nb) begin errors++; $display("FAIL b2b_busy_cycles: got %0d expected %0d", nb, exp_nb); end
    checks++; if (de !== 1'b1 || rh !== 32'd0 || rl !== 32'd143) begin errors++; $display("FAIL b2b_second: got done=%b %h_%h expected done=1 00000000_0000008f", de, rh, rl); end
  endtask

  task automatic test_reset_mid();
    int nb, he, db, done_seen;
    logic de;
    logic [31:0] rh, rl;
    int rst_cyc;
    rst_cyc = EARLY ? 2 : 10;
    run_op(32'd2, 32'd3, 1'b0, 0, 32'h0, 32'h0, nb, he, db, de, rh, rl);
    a = 32'd7;
    b = 32'd7;
    is_signed = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (rst_cyc - 1) begin
      @(posedge clk); #1;
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b expected 1", busy); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL rstmid_result: got %h_%h expected 00000000_00000000", hi, lo); end
    done_seen = (done !== 1'b0) ? 1 : 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) done_seen++;
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d active cycles expected 0", done_seen); end
    run_op(32'd4, 32'd4, 1'b0, 0, 32'h0, 32'h0, nb, he, db, de, rh, rl);
    checks++; if (de !== 1'b1 || rh !== 32'd0 || rl !== 32'd16) begin errors++; $display("FAIL rstmid_fresh: got done=%b %h_%h expected done=1 00000000_00000010", de, rh, rl); end
  endtask

  task automatic test_early_out();
    int nb, he, db;
    logic de;
    logic [31:0] rh, rl;
    int exp1, exp2;
    exp1 = EARLY ? 2 : 33;
    exp2 = EARLY ? 10 : 33;
    run_op(32'h1234_5678, 32'h1, 1'b0, 0, 32'h0, 32'h0, nb, he, db, de, rh, rl);
    checks++; if (nb !== exp1) begin errors++; $display("FAIL eo1_busy_cycles: got %0d expected %0d", nb, exp1); end
    checks++; if (rh !== 32'h0 || rl !== 32'h1234_5678) begin errors++; $display("FAIL eo1_result: got %h_%h expected 00000000_12345678", rh, rl); end
    run_op(32'h1234_5678, 32'h100, 1'b0, 0, 32'h0, 32'h0, nb, he, db, de, rh, rl);
    checks++; if (nb !== exp2) begin errors++; $display("FAIL eo2_busy_cycles: got %0d expected %0d", nb, exp2); end
    checks++; if (rh !== 32'h12 || rl !== 32'h3456_7800) begin errors++; $display("FAIL eo2_result: got %h_%h expected 00000012_34567800", rh, rl); end
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_early_out();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
